// File: rtl/inst_encoder_if.sv
// Request/response bundle for the instruction encoder: field-level request
// channel in, 32-bit instruction FIFO channel out, plus error and counter status.
interface inst_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [2:0]       kind_i;
  logic [2:0]       funct3_i;
  logic [6:0]       funct7_i;
  logic [4:0]       rd_i;
  logic [4:0]       rs1_i;
  logic [4:0]       rs2_i;
  logic [12:0]      imm_i;
  logic [31:0]      inst_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             err_o;
  logic             err_clr_i;
  logic [CNT_W-1:0] emit_cnt_o;

  modport master (
    output in_valid_i, kind_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i,
           out_ready_i, err_clr_i,
    input  in_ready_o, inst_o, out_valid_o, err_o, emit_cnt_o
  );

  modport slave (
    input  in_valid_i, kind_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i,
           out_ready_i, err_clr_i,
    output in_ready_o, inst_o, out_valid_o, err_o, emit_cnt_o
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs R/addi/ld/sd/beq fields into RV64I instruction words and queues them
// in a small output FIFO; illegal requests are consumed and flagged.
module inst_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  inst_encoder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  function automatic logic [31:0] encode(
    input logic [2:0]         kind,
    input logic [2:0]         f3,
    input logic [6:0]         f7,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic signed [12:0] imm
  );
    logic [31:0] w;
    w = '0;
    case (kind)
      3'd0:    w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      3'd1:    w = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      3'd2:    w = {imm[11:0], rs1, 3'b011, rd, 7'b0000011};
      3'd3:    w = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      3'd4:    w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default: w = '0;
    endcase
    return w;
  endfunction

  // I/S immediates must fit 12-bit signed; branch offsets must be halfword aligned.
  function automatic logic is_legal(input logic [2:0] kind, input logic signed [12:0] imm);
    logic ok;
    ok = 1'b0;
    case (kind)
      3'd0:              ok = 1'b1;
      3'd1, 3'd2, 3'd3:  ok = (imm[12] == imm[11]);
      3'd4:              ok = ~imm[0];
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [31:0]        mem [DEPTH];
  logic [OCC_W-1:0]   occ_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [31:0]        inst_p1;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               in_ready;
  logic               accept_p0;
  logic               push_p0;
  logic               bad_p0;
  logic               pop;
  logic signed [12:0] imm_p0;
  logic [31:0]        word_p0;
  logic [OCC_W-1:0]   occ_drain;
  logic [OCC_W-1:0]   occ_next;
  logic [PTR_W-1:0]   rd_ptr_next;

  always_comb begin
    imm_p0      = $signed(bus.imm_i);
    in_ready    = rst_i && (occ_q < FULL_OCC);
    accept_p0   = bus.in_valid_i && in_ready;
    push_p0     = accept_p0 && is_legal(bus.kind_i, imm_p0);
    bad_p0      = accept_p0 && !is_legal(bus.kind_i, imm_p0);
    word_p0     = encode(bus.kind_i, bus.funct3_i, bus.funct7_i,
                         bus.rd_i, bus.rs1_i, bus.rs2_i, imm_p0);
    pop         = (occ_q != '0) && bus.out_ready_i;
    occ_drain   = occ_q - OCC_W'(pop);
    occ_next    = occ_drain + OCC_W'(push_p0);
    rd_ptr_next = rd_ptr_q + PTR_W'(pop);
  end

  // ---- p0 -> p1: FIFO storage and registered head ----
  always_ff @(posedge clk_i) begin
    if (push_p0) mem[wr_ptr_q] <= word_p0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      inst_p1  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_next;
      rd_ptr_q <= rd_ptr_next;
      if (push_p0) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      // Head comes from the incoming word only when the queue would otherwise be empty.
      if (occ_next != '0) inst_p1 <= (occ_drain == '0) ? word_p0 : mem[rd_ptr_next];
      if (bad_p0)              err_q <= 1'b1;
      else if (bus.err_clr_i)  err_q <= 1'b0;
      if (pop) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.inst_o      = inst_p1;
  assign bus.out_valid_o = (occ_q != '0);
  assign bus.err_o       = err_q;
  assign bus.emit_cnt_o  = cnt_q;
endmodule
